// File: rtl/gray_decoder_checker.sv
// rtl/gray_decoder_checker.sv - Gray counter receive-side decoder and step checker.
// Decodes each enabled Gray sample, verifies it is previous+1 and counts step errors.
module gray_decoder_checker #(
  parameter int WIDTH = 5,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             enable,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out,
  output logic             valid_out,
  output logic             step_error,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACQUIRE,
    S_TRACK,
    S_RESYNC
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_ref;
  logic [WIDTH-1:0] w_decode;
  logic [WIDTH-1:0] w_expected;
  logic             w_match;
  logic             w_err_pulse;
  logic             w_err_sat;

  // Each binary bit is the XOR of its Gray bit and every more-significant Gray bit.
  always_comb begin
    w_decode = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_decode[i] = ^(gray_in >> i);
    end
  end

  assign w_expected = r_ref + WIDTH'(1);
  assign w_match    = (w_decode == w_expected);
  assign w_err_sat  = &err_count;

  always_comb begin
    w_next_state = r_state;
    w_err_pulse  = 1'b0;
    if (!enable) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    w_next_state = S_ACQUIRE;
        S_ACQUIRE: w_next_state = S_TRACK;
        S_TRACK: begin
          if (!w_match) begin
            w_next_state = S_RESYNC;
            w_err_pulse  = 1'b1;
          end
        end
        S_RESYNC: begin
          if (w_match) begin
            w_next_state = S_TRACK;
          end
        end
        default:   w_next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state    <= S_IDLE;
      r_ref      <= '0;
      bin_out    <= '0;
      valid_out  <= 1'b0;
      step_error <= 1'b0;
      locked     <= 1'b0;
      err_count  <= '0;
    end else begin
      r_state    <= w_next_state;
      valid_out  <= enable;
      step_error <= w_err_pulse;
      locked     <= (w_next_state == S_TRACK);
      // While disabled the last decode and reference are deliberately held.
      if (enable) begin
        bin_out <= w_decode;
        r_ref   <= w_decode;
      end
      if (w_err_pulse && !w_err_sat) begin
        err_count <= err_count + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_gray_decoder_checker.sv
// tb/tb_gray_decoder_checker.sv - Self-checking bench for gray_decoder_checker.
// Randomized and directed Gray streams checked against a sample-level reference model.
module tb_gray_decoder_checker;

  logic       clk;
  logic       reset_L;
  logic       enable;
  logic [4:0] gray_in;
  logic [4:0] bin_out;
  logic       valid_out;
  logic       step_error;
  logic       locked;
  logic [7:0] err_count;

  int checks;
  int failures;

  // Reference model: counts enabled samples since (re)enable and whether we are in sync.
  int         m_run;
  bit         m_sync;
  int         m_ref;
  logic [4:0] exp_bin;
  logic       exp_valid;
  logic       exp_step;
  logic       exp_locked;
  logic [7:0] exp_err;

  gray_decoder_checker #(.WIDTH(5), .ERR_W(8)) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .enable     (enable),
    .gray_in    (gray_in),
    .bin_out    (bin_out),
    .valid_out  (valid_out),
    .step_error (step_error),
    .locked     (locked),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] to_gray(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic int from_gray(input logic [4:0] g);
    for (int b = 0; b < 32; b++) begin
      if (to_gray(b) == g) return b;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_run = 0; m_sync = 0; m_ref = 0;
    exp_bin = '0; exp_valid = 0; exp_step = 0; exp_locked = 0; exp_err = '0;
  endtask

  // Drive one sample, clock it in, and advance the model; no checking here.
  task automatic drive(input bit en, input logic [4:0] g);
    int  d;
    bit  ok;
    enable  = en;
    gray_in = g;
    @(posedge clk);
    #1;
    if (!en) begin
      m_run = 0; exp_valid = 0; exp_step = 0; exp_locked = 0;
    end else begin
      d = from_gray(g);
      exp_bin = 5'(d); exp_valid = 1; exp_step = 0;
      if (m_run < 2) begin
        m_sync = (m_run == 1);
        m_run++;
      end else begin
        ok = (d == (m_ref + 1) % 32);
        if (m_sync && !ok) begin
          exp_step = 1;
          if (exp_err < 8'd255) exp_err = exp_err + 8'd1;
        end
        m_sync = ok;
      end
      m_ref = d;
      exp_locked = m_sync;
    end
  endtask

  task automatic test_reset();
    reset_L = 0; enable = 0; gray_in = '0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({bin_out, valid_out, step_error, locked, err_count} !== 16'h0) begin
        failures++;
        $display("FAIL reset_hold got=%h want=0000", {bin_out, valid_out, step_error, locked, err_count});
      end
    end
    reset_L = 1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 5'($urandom_range(0, 31)));
      checks++;
      if ({bin_out, valid_out, step_error, locked, err_count} !== 16'h0) begin
        failures++;
        $display("FAIL idle_disabled got=%h want=0000", {bin_out, valid_out, step_error, locked, err_count});
      end
    end
  endtask

  task automatic test_count_up();
    for (int b = 0; b < 5; b++) begin
      drive(1, to_gray(b));
      checks++;
      if ({bin_out, valid_out, step_error, locked, err_count} !==
          {exp_bin, exp_valid, exp_step, exp_locked, exp_err}) begin
        failures++;
        $display("FAIL count_up[%0d] got=%h want=%h", b,
                 {bin_out, valid_out, step_error, locked, err_count},
                 {exp_bin, exp_valid, exp_step, exp_locked, exp_err});
      end
      checks++;
      if (locked !== (b >= 1)) begin
        failures++;
        $display("FAIL count_up_locked[%0d] got=%b want=%b", b, locked, (b >= 1));
      end
    end
    checks++;
    if (bin_out !== 5'd4 || err_count !== 8'd0) begin
      failures++;
      $display("FAIL count_up_end got bin=%0d err=%0d want bin=4 err=0", bin_out, err_count);
    end
  endtask

  task automatic test_wrap();
    for (int b = 5; b < 34; b++) begin
      drive(1, to_gray(b % 32));
      checks++;
      if ({bin_out, valid_out, step_error, locked, err_count} !==
          {exp_bin, exp_valid, exp_step, exp_locked, exp_err}) begin
        failures++;
        $display("FAIL wrap[%0d] got=%h want=%h", b,
                 {bin_out, valid_out, step_error, locked, err_count},
                 {exp_bin, exp_valid, exp_step, exp_locked, exp_err});
      end
      if (b == 31) begin
        checks++;
        if (bin_out !== 5'd31) begin
          failures++;
          $display("FAIL wrap_top got=%0d want=31", bin_out);
        end
      end
    end
    checks++;
    if (bin_out !== 5'd1 || err_count !== 8'd0 || locked !== 1'b1) begin
      failures++;
      $display("FAIL wrap_end got bin=%0d err=%0d lock=%b want bin=1 err=0 lock=1", bin_out, err_count, locked);
    end
  endtask

  task automatic test_skip();
    int seq[6] = '{2, 3, 4, 6, 7, 8};
    for (int i = 0; i < 6; i++) begin
      drive(1, to_gray(seq[i]));
      checks++;
      if ({bin_out, valid_out, step_error, locked, err_count} !==
          {exp_bin, exp_valid, exp_step, exp_locked, exp_err}) begin
        failures++;
        $display("FAIL skip[%0d] got=%h want=%h", seq[i],
                 {bin_out, valid_out, step_error, locked, err_count},
                 {exp_bin, exp_valid, exp_step, exp_locked, exp_err});
      end
      if (seq[i] == 6) begin
        checks++;
        if (step_error !== 1'b1 || locked !== 1'b0 || err_count !== 8'd1) begin
          failures++;
          $display("FAIL skip_pulse got step=%b lock=%b err=%0d want 1 0 1", step_error, locked, err_count);
        end
      end
      if (seq[i] == 7) begin
        checks++;
        if (step_error !== 1'b0 || locked !== 1'b1) begin
          failures++;
          $display("FAIL skip_relock got step=%b lock=%b want 0 1", step_error, locked);
        end
      end
    end
  endtask

  task automatic test_random_burst();
    int prev;
    int v;
    int pulses;
    prev = 8;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      do v = $urandom_range(0, 31); while (v == (prev + 1) % 32);
      drive(1, to_gray(v));
      prev = v;
      if (step_error === 1'b1) pulses++;
      checks++;
      if ({bin_out, valid_out, step_error, locked, err_count} !==
          {exp_bin, exp_valid, exp_step, exp_locked, exp_err}) begin
        failures++;
        $display("FAIL random[%0d] got=%h want=%h", i,
                 {bin_out, valid_out, step_error, locked, err_count},
                 {exp_bin, exp_valid, exp_step, exp_locked, exp_err});
      end
    end
    checks++;
    if (pulses != 1 || err_count !== 8'd2) begin
      failures++;
      $display("FAIL random_burst got pulses=%0d err=%0d want 1 2", pulses, err_count);
    end
    drive(1, to_gray((prev + 1) % 32));
    drive(1, to_gray((prev + 2) % 32));
    checks++;
    if (locked !== 1'b1 || locked !== exp_locked) begin
      failures++;
      $display("FAIL random_relock got lock=%b want 1", locked);
    end
  endtask

  task automatic test_saturation();
    int cur;
    cur = m_ref;
    for (int i = 0; i < 300; i++) begin
      drive(1, to_gray((cur + 2) % 32));
      checks++;
      if ({bin_out, valid_out, step_error, locked, err_count} !==
          {exp_bin, exp_valid, exp_step, exp_locked, exp_err} || step_error !== 1'b1) begin
        failures++;
        $display("FAIL sat_err[%0d] got=%h want=%h", i,
                 {bin_out, valid_out, step_error, locked, err_count},
                 {exp_bin, exp_valid, exp_step, exp_locked, exp_err});
      end
      drive(1, to_gray((cur + 3) % 32));
      cur = (cur + 3) % 32;
      checks++;
      if ({bin_out, valid_out, step_error, locked, err_count} !==
          {exp_bin, exp_valid, exp_step, exp_locked, exp_err}) begin
        failures++;
        $display("FAIL sat_ok[%0d] got=%h want=%h", i,
                 {bin_out, valid_out, step_error, locked, err_count},
                 {exp_bin, exp_valid, exp_step, exp_locked, exp_err});
      end
    end
    checks++;
    if (err_count !== 8'd255) begin
      failures++;
      $display("FAIL saturate got=%0d want=255", err_count);
    end
  endtask

  task automatic test_pause();
    int cur;
    logic [4:0] held;
    cur = m_ref;
    held = bin_out;
    // Enable drops on the same edge as a mismatching sample: no pulse.
    drive(0, to_gray((cur + 5) % 32));
    checks++;
    if (step_error !== 1'b0 || valid_out !== 1'b0 || locked !== 1'b0 || bin_out !== held) begin
      failures++;
      $display("FAIL pause_drop got step=%b valid=%b lock=%b bin=%0d want 0 0 0 %0d",
               step_error, valid_out, locked, bin_out, held);
    end
    drive(0, 5'($urandom_range(0, 31)));
    cur = $urandom_range(0, 31);
    for (int i = 0; i < 4; i++) begin
      drive(1, to_gray((cur + i) % 32));
      checks++;
      if ({bin_out, valid_out, step_error, locked, err_count} !==
          {exp_bin, exp_valid, exp_step, exp_locked, exp_err} || step_error !== 1'b0) begin
        failures++;
        $display("FAIL pause_resume[%0d] got=%h want=%h", i,
                 {bin_out, valid_out, step_error, locked, err_count},
                 {exp_bin, exp_valid, exp_step, exp_locked, exp_err});
      end
    end
  endtask

  task automatic test_async_reset();
    int cur;
    cur = m_ref;
    drive(1, to_gray((cur + 1) % 32));
    #2;
    reset_L = 0;
    #1;
    model_reset();
    checks++;
    if ({bin_out, valid_out, step_error, locked, err_count} !== 16'h0) begin
      failures++;
      $display("FAIL async_reset got=%h want=0000", {bin_out, valid_out, step_error, locked, err_count});
    end
    @(posedge clk); #3;
    reset_L = 1;
    cur = $urandom_range(0, 31);
    for (int i = 0; i < 4; i++) begin
      drive(1, to_gray((cur + i * 7) % 32));
      checks++;
      if ({bin_out, valid_out, step_error, locked, err_count} !==
          {exp_bin, exp_valid, exp_step, exp_locked, exp_err}) begin
        failures++;
        $display("FAIL post_reset[%0d] got=%h want=%h", i,
                 {bin_out, valid_out, step_error, locked, err_count},
                 {exp_bin, exp_valid, exp_step, exp_locked, exp_err});
      end
      if (i < 2) begin
        checks++;
        if (step_error !== 1'b0) begin
          failures++;
          $display("FAIL post_reset_acquire[%0d] got step=%b want 0", i, step_error);
        end
      end
    end
  endtask

  initial begin
    clk = 0; reset_L = 0; enable = 0; gray_in = '0;
    checks = 0; failures = 0;
    test_reset();
    test_count_up();
    test_wrap();
    test_skip();
    test_random_burst();
    test_saturation();
    test_pause();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gray_decoder_checker.md
Name: gray_decoder_checker

Overview:
- Receive end of the 5-bit Gray counter interface: samples the counter's Gray output every clock, decodes it to binary, and checks that each sample is exactly one count above the previous one (modulo 2^WIDTH).
- Sits downstream of the Gray counter, in place of the bench comparator, as a synthesizable self-check.
- Reports the decoded value, a per-cycle step-error pulse, a lock indication and a saturating error count.

Parameters:
- WIDTH, 5, width of the Gray input and the decoded binary output.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset_L  input  1  asynchronous, active-low reset.
- enable  input  1  checking enable; mirrors the counter's enable.
- gray_in  input  WIDTH  Gray-coded count from the counter.
- bin_out  output  WIDTH  registered binary decode of gray_in.
- valid_out  output  1  bin_out holds a decode of a sample taken while enable=1.
- step_error  output  1  one-cycle pulse: the sample is not previous+1.
- locked  output  1  high while the FSM is in TRACK.
- err_count  output  ERR_W  number of step errors since reset; saturates at all-ones.

Behaviour:
- Reset (reset_L=0, asynchronous): bin_out=0, valid_out=0, step_error=0, locked=0, err_count=0, ref register=0, state=IDLE. Reset mid-operation aborts immediately; no partial update survives.
- Decode (combinational): b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i].
- Output latency: bin_out and valid_out are registered and reflect the gray_in sampled at the previous posedge (1 cycle). step_error and locked update on the same edge as the bin_out they qualify.
- The ref register holds the last accepted binary value. Expected value = ref+1, truncated to WIDTH bits, so 31 is followed by 0 with no error.
- IDLE:
  - valid_out=0, step_error=0.
  - enable=1 -> ACQUIRE.
- ACQUIRE (first enabled sample):
  - ref<=decode, bin_out<=decode, valid_out=1, no check.
  - -> TRACK.
- TRACK (locked=1):
  - Each cycle, bin_out<=decode and valid_out=1.
  - If decode==ref+1: ref<=decode, step_error=0, stay in TRACK.
  - Otherwise: step_error=1 for one cycle, err_count+=1 unless saturated, ref<=decode, -> RESYNC.
- RESYNC (locked=0):
  - bin_out<=decode, valid_out=1, ref<=decode every cycle.
  - If decode==old ref+1: -> TRACK.
  - Otherwise: stay in RESYNC, with no further step_error and no further count. Only the first mismatch of a burst is counted.
- enable=0 in any state: -> IDLE on the next edge. valid_out=0, step_error=0 and locked=0 on that edge. bin_out keeps its last value; err_count and ref are held.
- Re-enabling always passes through ACQUIRE, so a counter paused and resumed is never flagged.
- Simultaneous events:
  - enable falling in the same cycle as a mismatch: IDLE wins, with no error pulse or count.
  - Saturation: err_count stays at 2^ERR_W-1 while step_error keeps pulsing.
- err_count clears only on reset.

Test Plan:
- Reset for 3 cycles, release, hold enable=0 for 3 cycles -> all outputs 0 and locked=0 throughout.
- Enable, drive Gray 00000,00001,00011,00010,00110 on successive cycles -> bin_out 0,1,2,3,4 one cycle later; locked rises on the second valid sample; step_error never asserts.
- Run the full sequence through Gray 10000 (bin 31) then 00000 -> bin_out 31 then 0; no step_error; err_count stays 0.
- While locked at bin 4 (Gray 00110), inject Gray 00101 (bin 6), then resume 00100 (7), 01100 (8) -> step_error pulses once; err_count=1; locked drops for one cycle and returns on bin 7.
- Drive random non-sequential Gray values for 10 cycles -> exactly one step_error and err_count+1. Then drive 300 isolated single-skip errors -> err_count saturates at 255.
- Assert reset_L low mid-TRACK between clock edges -> outputs clear immediately (asynchronously). After release with enable=1, the FSM goes through ACQUIRE with no error pulse.
